multi_ping_pong_buffer: RTL and testbench
=========================================

// Module: multi_ping_pong_buffer
// PURPOSE
//  CHANNELS-wide, two-bank ping-pong buffer with a full/empty handshake for each bank.
//  It generalises the per-column fm/guard buffers to one block covering every PE column,
//  with the bank swap controlled by hardware instead of a raw ping_pong input.
//  The writer (PE write-back) fills one bank while the reader (next layer feed) drains the other.
//  Each committed bank records its valid length.
// PARAMETERS
//  WIDTH     8                       data bits per channel word (8 = feature map, 6 = guard)
//  DEPTH     256                     words per bank per channel; any value >= 2
//  CHANNELS  8                       independent lanes, one per PE column (CONF_PE_COL)
//  AW        $clog2(DEPTH)           address width (derived, not overridden)
// PORTS
//  clk          in   1               single clock; all logic on the rising edge
//  rst          in   1               synchronous, active-high reset
//  wr_ready     out  1               the write bank is EMPTY and accepts writes and a commit
//  wr_en        in   CHANNELS        per-channel write strobe
//  wr_addr      in   CHANNELS*AW     per-channel write address; channel c at [c*AW +: AW]
//  wr_data      in   CHANNELS*WIDTH  per-channel write data
//  wr_commit    in   1               close the write bank; it becomes FULL
//  wr_len       in   AW+1            valid word count stored with the commit (0..DEPTH)
//  rd_valid     out  1               the read bank is FULL
//  rd_len       out  AW+1            stored length of the read bank; 0 when rd_valid=0
//  rd_en        in   CHANNELS        per-channel read strobe
//  rd_addr      in   CHANNELS*AW     per-channel read address
//  rd_data      out  CHANNELS*WIDTH  registered read data
//  rd_release   in   1               reader done; the read bank returns to EMPTY
//  full_cnt     out  2               number of FULL banks (0..2)
//  err          out  1               sticky protocol error; cleared only by rst
// BEHAVIOUR
//  - State: bank_full[1:0], wb (write bank pointer), rb (read bank pointer), len[0:1].
//  - Reset: bank_full=0, wb=0, rb=0, len=0, rd_data=0, err=0.
//    After reset: wr_ready=1, rd_valid=0, full_cnt=0, rd_len=0.
//    Memory contents are not cleared.
//  - wr_ready = !bank_full[wb]; rd_valid = bank_full[rb]. Both are combinational from registers.
//  - Write: a write with wr_en[c]=1, wr_ready=1 and addr<DEPTH stores wr_data[c] to mem[c][wb][addr].
//    Write-to-read latency: 1 cycle.
//  - Commit with wr_commit=1 and wr_ready=1:
//    - bank_full[wb]<=1; len[wb]<=min(wr_len,DEPTH); wb<=~wb.
//    - Writes in the same cycle still land in the old bank.
//  - Read: rd_en[c]=1 gives rd_data[c]=mem[c][rb][rd_addr[c]] on the next edge.
//    - rd_en[c]=0 holds rd_data[c].
//    - A read is performed even when rd_valid=0 (stale data, no error).
//  - Release with rd_release=1 and rd_valid=1: bank_full[rb]<=0; rb<=~rb.
//    Reads in the same cycle use the old rb.
//  - Simultaneous commit and release are both applied in the same cycle.
//    Commit needs an EMPTY bank and release needs a FULL bank, so they never target the same bank.
//    full_cnt is unchanged in that case.
//  - Write into the read bank is impossible by construction.
//    With both banks FULL, wr_ready=0 and the writer stalls.
//  - Error events. Each sets err=1; the offending action is ignored and no state changes:
//    - wr_en while !wr_ready
//    - wr_commit while !wr_ready
//    - rd_release while !rd_valid
//    - wr_addr>=DEPTH (non-power-of-2 DEPTH)
//    - wr_len>DEPTH: err=1, and the length is clamped to DEPTH
//  - Pointer wrap: wb and rb toggle, so A,B,A,B... continues indefinitely.
//  - Reset mid-fill or mid-drain: all banks become EMPTY immediately.
//    Partial data is discarded logically.
// STRUCTURE
//  - Add to diff_core_pkg: typedef logic [1:0] bank_vec_t, and CONF_FM_BUF_DEPTH / CONF_GUARD_BUF_DEPTH.
//    Top-level instances use these as DEPTH.
//  - Sub-module ppbuf_lane_mem: simple dual-port RAM of 2*DEPTH x WIDTH.
//    - Write address {wb, wr_addr}; read address {rb, rd_addr}; registered output.
//    - Generate one per channel.
//  - Control (pointers, bank_full, len, err) is a single shared instance in this module.
// TESTING
//  - Reset, then idle: wr_ready=1, rd_valid=0, full_cnt=0, rd_len=0, err=0, rd_data=0.
//  - Fill ch0..7: addr 0..3 with data c*16+a; commit wr_len=4.
//    Expect rd_valid=1 and rd_len=4 next cycle; reading ch3 addr2 returns 0x32 one cycle after rd_en.
//  - Commit bank A (len 4), then bank B (len 9): full_cnt=2, wr_ready=0.
//    wr_en now -> err=1, bank contents unchanged.
//  - Release A in the same cycle as commit B: full_cnt stays 1.
//    rb->B, wb->A, rd_len=9 next cycle.
//  - wr_len=300 with DEPTH=256 -> rd_len=256, err=1.
//    rd_release with rd_valid=0 -> err=1 and rb unchanged.
//  - Assert rst during fill of the second bank (one bank FULL).
//    Next cycle: full_cnt=0, wb=rb=0, wr_ready=1, rd_valid=0, err=0.

Source files
------------

// File: rtl/diff_core_pkg.sv
// Shared configuration and types for the diffusion core datapath.
// Buffer depths here are the DEPTH values used by top-level ping-pong buffer instances.
package diff_core_pkg;

    typedef logic [1:0] bank_vec_t;

    localparam int CONF_PE_COL          = 8;
    localparam int CONF_FM_BUF_DEPTH    = 256;
    localparam int CONF_GUARD_BUF_DEPTH = 256;

    function automatic logic [1:0] countFull(input bank_vec_t v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/ppbuf_lane_mem.sv
// One lane of the ping-pong buffer: dual-port RAM holding both banks of a single channel.
// The bank select is the MSB of each address; read data is registered and held when not reading.
module ppbuf_lane_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [AW:0]      wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW:0]      rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    // Sized to the full {bank, addr} span so non-power-of-2 DEPTH still indexes safely.
    logic [WIDTH-1:0] mem_q [2**(AW+1)];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/multi_ping_pong_buffer.sv
// Multi-channel two-bank ping-pong buffer with hardware-managed bank swap.
// Writer fills bank wb while reader drains bank rb; commit/release hand banks between them.
module multi_ping_pong_buffer
    import diff_core_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = CONF_FM_BUF_DEPTH,
    parameter int CHANNELS = CONF_PE_COL,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic                      wr_ready_o,
    input  logic [CHANNELS-1:0]       wr_en_i,
    input  logic [CHANNELS*AW-1:0]    wr_addr_i,
    input  logic [CHANNELS*WIDTH-1:0] wr_data_i,
    input  logic                      wr_commit_i,
    input  logic [AW:0]               wr_len_i,
    output logic                      rd_valid_o,
    output logic [AW:0]               rd_len_o,
    input  logic [CHANNELS-1:0]       rd_en_i,
    input  logic [CHANNELS*AW-1:0]    rd_addr_i,
    output logic [CHANNELS*WIDTH-1:0] rd_data_o,
    input  logic                      rd_release_i,
    output logic [1:0]                full_cnt_o,
    output logic                      err_o
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    bank_vec_t           bankFull_q, bankFull_d;
    logic                wb_q, wb_d, rb_q, rb_d;
    logic [AW:0]         len_q [2];
    logic [AW:0]         len_d [2];
    logic                err_q, err_d;

    logic                wrReady, rdValid, commitOk, releaseOk, lenOver, badAddr;
    logic [CHANNELS-1:0] laneWrEn;

    assign wrReady    = !bankFull_q[wb_q];
    assign rdValid    = bankFull_q[rb_q];
    assign wr_ready_o = wrReady;
    assign rd_valid_o = rdValid;
    assign rd_len_o   = rdValid ? len_q[rb_q] : '0;
    assign full_cnt_o = countFull(bankFull_q);
    assign err_o      = err_q;

    // Commit and release always target different banks, so both may apply in one cycle.
    always_comb begin
        bankFull_d = bankFull_q;
        wb_d       = wb_q;
        rb_d       = rb_q;
        len_d      = len_q;
        laneWrEn   = '0;
        badAddr    = 1'b0;
        commitOk   = wr_commit_i && wrReady;
        releaseOk  = rd_release_i && rdValid;
        lenOver    = wr_len_i > DEPTH_W;

        for (int c = 0; c < CHANNELS; c++) begin
            if ({1'b0, wr_addr_i[c*AW +: AW]} < DEPTH_W) begin
                laneWrEn[c] = wr_en_i[c] && wrReady;
            end else begin
                badAddr = badAddr || wr_en_i[c];
            end
        end

        if (commitOk) begin
            bankFull_d[wb_q] = 1'b1;
            len_d[wb_q]      = lenOver ? DEPTH_W : wr_len_i;
            wb_d             = !wb_q;
        end
        if (releaseOk) begin
            bankFull_d[rb_q] = 1'b0;
            rb_d             = !rb_q;
        end

        err_d = err_q
              || ((|wr_en_i) && !wrReady)
              || (wr_commit_i && !wrReady)
              || (rd_release_i && !rdValid)
              || badAddr
              || (commitOk && lenOver);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bankFull_q <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            err_q      <= 1'b0;
        end else begin
            bankFull_q <= bankFull_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            len_q      <= len_d;
            err_q      <= err_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : gLane
        ppbuf_lane_mem #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) uLane (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .wr_en_i  (laneWrEn[c]),
            .wr_addr_i({wb_q, wr_addr_i[c*AW +: AW]}),
            .wr_data_i(wr_data_i[c*WIDTH +: WIDTH]),
            .rd_en_i  (rd_en_i[c]),
            .rd_addr_i({rb_q, rd_addr_i[c*AW +: AW]}),
            .rd_data_o(rd_data_o[c*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_multi_ping_pong_buffer.sv
// Directed bench for multi_ping_pong_buffer: expected read words go through a scoreboard queue,
// control outputs are compared against constants derived from the buffer's handshake rules.
module tb_multi_ping_pong_buffer;

    localparam int CH = 8;
    localparam int W  = 8;
    localparam int D  = 256;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            wrReady;
    logic [CH-1:0]   wrEn;
    logic [CH*AW-1:0] wrAddr;
    logic [CH*W-1:0] wrData;
    logic            wrCommit;
    logic [AW:0]     wrLen;
    logic            rdValid;
    logic [AW:0]     rdLen;
    logic [CH-1:0]   rdEn;
    logic [CH*AW-1:0] rdAddr;
    logic [CH*W-1:0] rdData;
    logic            rdRelease;
    logic [1:0]      fullCnt;
    logic            err;

    int              nChecks = 0;
    int              nFail   = 0;
    logic [CH*W-1:0] expQ[$];
    logic [CH*W-1:0] lastExp = '0;

    multi_ping_pong_buffer #(
        .WIDTH(W),
        .DEPTH(D),
        .CHANNELS(CH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_ready_o  (wrReady),
        .wr_en_i     (wrEn),
        .wr_addr_i   (wrAddr),
        .wr_data_i   (wrData),
        .wr_commit_i (wrCommit),
        .wr_len_i    (wrLen),
        .rd_valid_o  (rdValid),
        .rd_len_o    (rdLen),
        .rd_en_i     (rdEn),
        .rd_addr_i   (rdAddr),
        .rd_data_o   (rdData),
        .rd_release_i(rdRelease),
        .full_cnt_o  (fullCnt),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int sel, input int c, input int a);
        case (sel)
            0:       return 8'(c*16 + a);
            1:       return 8'(a*16 + c);
            default: return 8'(c*16 + a) ^ 8'h5A;
        endcase
    endfunction

    // Advance one clock; everything after returns 1 time unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkRead(input string tag);
        logic [CH*W-1:0] exp;
        if (expQ.size() == 0) begin
            nChecks++;
            nFail++;
            $error("[TB] FAIL %s: observed=read-data expected=queued-entry", tag);
        end else begin
            exp = expQ.pop_front();
            checkOutput(tag, rdData, exp);
        end
    endtask

    task automatic writeRow(input int a, input int sel);
        for (int c = 0; c < CH; c++) begin
            wrAddr[c*AW +: AW] = AW'(a);
            wrData[c*W +: W]   = pat(sel, c, a);
        end
        wrEn = '1;
        tick();
        wrEn = '0;
    endtask

    task automatic doCommit(input int len);
        wrCommit = 1'b1;
        wrLen    = (AW+1)'(len);
        tick();
        wrCommit = 1'b0;
    endtask

    task automatic doRelease();
        rdRelease = 1'b1;
        tick();
        rdRelease = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input int base, input int n, input int sel);
        logic [CH*W-1:0] exp;
        for (int c = 0; c < CH; c++) begin
            rdAddr[c*AW +: AW] = AW'((base + c) % n);
            exp[c*W +: W]      = pat(sel, c, (base + c) % n);
        end
        expQ.push_back(exp);
        lastExp = exp;
        rdEn = '1;
        tick();
        rdEn = '0;
        checkRead(tag);
    endtask

    initial begin
        logic [CH*W-1:0] exp;
        rst = 1'b1; wrEn = '0; wrAddr = '0; wrData = '0; wrCommit = 1'b0; wrLen = '0;
        rdEn = '0; rdAddr = '0; rdRelease = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_wr_ready", 64'(wrReady), 64'd1);
        checkOutput("reset_rd_valid", 64'(rdValid), 64'd0);
        checkOutput("reset_full_cnt", 64'(fullCnt), 64'd0);
        checkOutput("reset_rd_len",   64'(rdLen),   64'd0);
        checkOutput("reset_err",      64'(err),     64'd0);
        checkOutput("reset_rd_data",  rdData,       64'd0);

        for (int a = 0; a < 4; a++) writeRow(a, 0);
        doCommit(4);
        checkOutput("commitA_rd_valid", 64'(rdValid), 64'd1);
        checkOutput("commitA_rd_len",   64'(rdLen),   64'd4);
        checkOutput("commitA_full_cnt", 64'(fullCnt), 64'd1);
        checkOutput("commitA_wr_ready", 64'(wrReady), 64'd1);

        // Only channel 3 reads; the other lanes must hold their reset value.
        exp = lastExp;
        exp[3*W +: W] = 8'h32;
        expQ.push_back(exp);
        lastExp = exp;
        rdAddr[3*AW +: AW] = AW'(2);
        rdEn = 8'h08;
        tick();
        rdEn = '0;
        checkRead("read_ch3_addr2");

        applyStimulus("readA_base0", 0, 4, 0);
        applyStimulus("readA_base3", 3, 4, 0);
        rdAddr = '0;
        expQ.push_back(lastExp);
        tick();
        checkRead("read_hold");

        for (int a = 0; a < 9; a++) writeRow(a, 1);
        wrCommit  = 1'b1;
        wrLen     = 9'd9;
        rdRelease = 1'b1;
        tick();
        wrCommit  = 1'b0;
        rdRelease = 1'b0;
        checkOutput("swap_full_cnt", 64'(fullCnt), 64'd1);
        checkOutput("swap_rd_len",   64'(rdLen),   64'd9);
        checkOutput("swap_wr_ready", 64'(wrReady), 64'd1);
        checkOutput("swap_err",      64'(err),     64'd0);
        applyStimulus("readB_base0", 0, 9, 1);
        applyStimulus("readB_base5", 5, 9, 1);

        for (int a = 0; a < 4; a++) writeRow(a, 2);
        doCommit(4);
        checkOutput("both_full_cnt", 64'(fullCnt), 64'd2);
        checkOutput("both_wr_ready", 64'(wrReady), 64'd0);
        checkOutput("both_rd_len",   64'(rdLen),   64'd9);
        writeRow(1, 1);
        checkOutput("stall_write_err", 64'(err), 64'd1);
        doRelease();
        checkOutput("relB_full_cnt", 64'(fullCnt), 64'd1);
        checkOutput("relB_rd_len",   64'(rdLen),   64'd4);
        applyStimulus("readA2_unchanged", 1, 4, 2);

        writeRow(0, 0);
        wrEn = '1;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        wrEn = '0;
        lastExp = '0;
        checkOutput("midrst_full_cnt", 64'(fullCnt), 64'd0);
        checkOutput("midrst_wr_ready", 64'(wrReady), 64'd1);
        checkOutput("midrst_rd_valid", 64'(rdValid), 64'd0);
        checkOutput("midrst_err",      64'(err),     64'd0);
        checkOutput("midrst_rd_data",  rdData,       64'd0);
        doCommit(3);
        checkOutput("postrst_rd_len", 64'(rdLen), 64'd3);
        applyStimulus("postrst_bank0", 0, 4, 2);

        doRelease();
        checkOutput("empty_rd_valid", 64'(rdValid), 64'd0);
        doRelease();
        checkOutput("bad_release_err", 64'(err), 64'd1);
        doCommit(5);
        checkOutput("rb_kept_rd_valid", 64'(rdValid), 64'd1);
        checkOutput("rb_kept_rd_len",   64'(rdLen),   64'd5);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        doCommit(300);
        checkOutput("len300_rd_len", 64'(rdLen), 64'd256);
        checkOutput("len300_err",    64'(err),   64'd1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        doCommit(256);
        checkOutput("len256_rd_len", 64'(rdLen), 64'd256);
        checkOutput("len256_err",    64'(err),   64'd0);
        doCommit(0);
        checkOutput("len0_full_cnt", 64'(fullCnt), 64'd2);
        doRelease();
        checkOutput("len0_rd_valid", 64'(rdValid), 64'd1);
        checkOutput("len0_rd_len",   64'(rdLen),   64'd0);
        doRelease();
        doCommit(7);
        checkOutput("wrap_rd_len",   64'(rdLen),   64'd7);
        checkOutput("wrap_full_cnt", 64'(fullCnt), 64'd1);
        checkOutput("final_err",     64'(err),     64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
